clock_mode_controller: RTL

- Controller that sequences the clock/alarm time registers for the VGA clock face.
- Owns hours/minutes/seconds and alarm hour/minute.
- Runs a button-driven set-mode FSM, raises the alarm, and drives a blink strobe so the renderer can flash the field being edited.
- Sits between the button debouncers (one-cycle pulses) and the clock renderer / buzzer logic.

---
 rtl/clock_ctrl_pkg.sv | 32 +++
 rtl/clock_mode_controller_if.sv | 34 +++
 rtl/clock_mode_controller_wrap_counter.sv | 38 +++
 rtl/clock_mode_controller.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/clock_ctrl_pkg.sv
// clock_ctrl_pkg
//   Shared constants for the clock face controller: field limits and widths,
//   edit-field codes and the set-mode state encoding (which is the same value
//   that is shown on edit_field).
package clock_ctrl_pkg;

  localparam int CLK_HZ  = 31_500_000;
  localparam int HR_MAX  = 11;
  localparam int MIN_MAX = 59;
  localparam int SEC_MAX = 59;
  localparam int HR_W    = 4;
  localparam int MIN_W   = 6;

  typedef enum logic [2:0] {
    EDIT_NONE   = 3'd0,
    EDIT_HR     = 3'd1,
    EDIT_MIN    = 3'd2,
    EDIT_AL_HR  = 3'd3,
    EDIT_AL_MIN = 3'd4
  } edit_field_e;

  localparam logic [2:0] ST_RUN        = 3'(EDIT_NONE);
  localparam logic [2:0] ST_SET_HR     = 3'(EDIT_HR);
  localparam logic [2:0] ST_SET_MIN    = 3'(EDIT_MIN);
  localparam logic [2:0] ST_SET_AL_HR  = 3'(EDIT_AL_HR);
  localparam logic [2:0] ST_SET_AL_MIN = 3'(EDIT_AL_MIN);

  function automatic logic [2:0] next_state(input logic [2:0] st);
    return (st == ST_SET_AL_MIN) ? ST_RUN : st + 3'd1;
  endfunction

endpackage

// File: rtl/clock_mode_controller_if.sv
// clock_mode_controller_if
//   Button pulses in, clock/alarm registers and renderer hints out.
//   master : debouncer/renderer side (drives pulses, reads fields)
//   slave  : clock_mode_controller
interface clock_mode_controller_if;
  import clock_ctrl_pkg::*;

  logic             tick_1hz;
  logic             mode_pulse;
  logic             inc_pulse;
  logic             al_toggle_pulse;
  logic             snooze_pulse;
  logic [HR_W-1:0]  hours;
  logic [MIN_W-1:0] minutes;
  logic [MIN_W-1:0] seconds;
  logic [HR_W-1:0]  al_hours;
  logic [MIN_W-1:0] al_minutes;
  logic             al_on;
  logic             alarm;
  logic [2:0]       edit_field;
  logic             blink;

  modport master (
    output tick_1hz, mode_pulse, inc_pulse, al_toggle_pulse, snooze_pulse,
    input  hours, minutes, seconds, al_hours, al_minutes, al_on, alarm,
           edit_field, blink
  );

  modport slave (
    input  tick_1hz, mode_pulse, inc_pulse, al_toggle_pulse, snooze_pulse,
    output hours, minutes, seconds, al_hours, al_minutes, al_on, alarm,
           edit_field, blink
  );
endinterface

// File: rtl/clock_mode_controller_wrap_counter.sv
// wrap_counter
//   Modulo-(MAX+1) counter with increment, synchronous clear and carry-out.
//   o_next exposes the value the register will take at the next edge so the
//   parent can compare post-increment values without an extra cycle.
//   Ports: video_clk, reset (sync, active-high), i_inc, i_clear,
//          o_count, o_next, o_carry (inc at MAX).
module wrap_counter
  import clock_ctrl_pkg::*;
#(
  parameter int MAX = SEC_MAX,
  parameter int W   = MIN_W
) (
  input  logic         video_clk,
  input  logic         reset,
  input  logic         i_inc,
  input  logic         i_clear,
  output logic [W-1:0] o_count,
  output logic [W-1:0] o_next,
  output logic         o_carry
);

  logic [W-1:0] r_count;

  assign o_count = r_count;
  assign o_carry = i_inc && (r_count == W'(MAX));

  always_comb begin
    o_next = r_count;
    if (i_clear || o_carry) o_next = '0;
    else if (i_inc)         o_next = r_count + 1'b1;
  end

  always_ff @(posedge video_clk) begin
    if (reset) r_count <= '0;
    else       r_count <= o_next;
  end

endmodule

// File: rtl/clock_mode_controller.sv
// clock_mode_controller
//   Time/alarm register owner for the VGA clock face: set-mode FSM, 1 Hz
//   timekeeping, alarm trigger/timeout and the blink strobe for the field
//   being edited.
//   Ports: video_clk, reset (sync, active-high), ctrl (slave modport:
//          pulses in; hours/minutes/seconds/al_*/al_on/alarm/edit_field/
//          blink out, all registered).
//   Optional: define CLOCK_CTRL_SNOOZE_EN to build the snooze counter.
//
//   state         | meaning
//   ST_RUN        | clock running, no field edited
//   ST_SET_HR     | editing hours, time frozen
//   ST_SET_MIN    | editing minutes, time frozen
//   ST_SET_AL_HR  | editing alarm hours, time running
//   ST_SET_AL_MIN | editing alarm minutes, time running
module clock_mode_controller
  import clock_ctrl_pkg::*;
#(
  parameter int BLINK_DIV       = CLK_HZ / 2,
  parameter int ALARM_TIMEOUT_S = 60,
  parameter int SNOOZE_S        = 300
) (
  input  logic                  video_clk,
  input  logic                  reset,
  clock_mode_controller_if.slave ctrl
);

  localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int TMO_W = $clog2(ALARM_TIMEOUT_S + 1);

  logic [2:0]       r_state;
  logic [BLK_W-1:0] r_blink_cnt;
  logic             r_blink;
  logic             r_al_on;
  logic             r_alarm;
  logic [TMO_W-1:0] r_tmo;

  logic             w_tick_run, w_inc_edit, w_match, w_turn_off;
  logic [HR_W-1:0]  w_hr, w_hr_next, w_al_hr, w_al_hr_next;
  logic [MIN_W-1:0] w_min, w_min_next, w_sec, w_sec_next, w_al_min, w_al_min_next;
  logic             w_sec_carry, w_min_carry;
  logic             w_unused_hr_carry, w_unused_al_hr_carry, w_unused_al_min_carry;

  // Time is frozen only while hours/minutes are being set.
  assign w_tick_run = ctrl.tick_1hz &&
                      !(r_state == ST_SET_HR || r_state == ST_SET_MIN);
  assign w_inc_edit = ctrl.inc_pulse && !ctrl.mode_pulse;

  wrap_counter #(.MAX(SEC_MAX), .W(MIN_W)) u_sec (
    .video_clk, .reset,
    .i_inc   (w_tick_run),
    .i_clear (ctrl.mode_pulse && r_state == ST_SET_MIN),
    .o_count (w_sec), .o_next (w_sec_next), .o_carry (w_sec_carry));

  wrap_counter #(.MAX(MIN_MAX), .W(MIN_W)) u_min (
    .video_clk, .reset,
    .i_inc   (w_sec_carry || (w_inc_edit && r_state == ST_SET_MIN)),
    .i_clear (1'b0),
    .o_count (w_min), .o_next (w_min_next), .o_carry (w_min_carry));

  // Minute carry from an edit must not ripple into hours.
  wrap_counter #(.MAX(HR_MAX), .W(HR_W)) u_hr (
    .video_clk, .reset,
    .i_inc   ((w_tick_run && w_min_carry) || (w_inc_edit && r_state == ST_SET_HR)),
    .i_clear (1'b0),
    .o_count (w_hr), .o_next (w_hr_next), .o_carry (w_unused_hr_carry));

  wrap_counter #(.MAX(HR_MAX), .W(HR_W)) u_al_hr (
    .video_clk, .reset,
    .i_inc   (w_inc_edit && r_state == ST_SET_AL_HR),
    .i_clear (1'b0),
    .o_count (w_al_hr), .o_next (w_al_hr_next), .o_carry (w_unused_al_hr_carry));

  wrap_counter #(.MAX(MIN_MAX), .W(MIN_W)) u_al_min (
    .video_clk, .reset,
    .i_inc   (w_inc_edit && r_state == ST_SET_AL_MIN),
    .i_clear (1'b0),
    .o_count (w_al_min), .o_next (w_al_min_next), .o_carry (w_unused_al_min_carry));

  // Only a running-time tick that lands on :00 can trigger, so edits never do.
  assign w_match = w_tick_run && r_al_on && (w_sec_next == '0) &&
                   (w_hr_next == w_al_hr_next) && (w_min_next == w_al_min_next);
  assign w_turn_off = ctrl.al_toggle_pulse && r_al_on;

  always_ff @(posedge video_clk) begin
    if (reset) begin
      r_state     <= ST_RUN;
      r_blink_cnt <= '0;
      r_blink     <= 1'b1;
    end else if (ctrl.mode_pulse) begin
      r_state     <= next_state(r_state);
      r_blink_cnt <= '0;
      r_blink     <= 1'b1;
    end else if (r_state == ST_RUN) begin
      r_blink_cnt <= '0;
      r_blink     <= 1'b1;
    end else if (r_blink_cnt == BLK_W'(BLINK_DIV - 1)) begin
      r_blink_cnt <= '0;
      r_blink     <= ~r_blink;
    end else begin
      r_blink_cnt <= r_blink_cnt + 1'b1;
    end
  end

`ifdef CLOCK_CTRL_SNOOZE_EN
  localparam int SNZ_W = $clog2(SNOOZE_S + 1);

  logic             r_snz_pend;
  logic [SNZ_W-1:0] r_snz_cnt;
  logic             w_snz_expire;

  assign w_snz_expire = ctrl.tick_1hz && r_snz_pend && (r_snz_cnt == SNZ_W'(1)) &&
                        !w_turn_off && !w_match;

  always_ff @(posedge video_clk) begin
    if (reset) begin
      r_snz_pend <= 1'b0;
      r_snz_cnt  <= '0;
    end else if (w_turn_off || w_match) begin
      r_snz_pend <= 1'b0;
    end else if (ctrl.snooze_pulse && r_alarm) begin
      r_snz_pend <= 1'b1;
      r_snz_cnt  <= SNZ_W'(SNOOZE_S);
    end else if (ctrl.tick_1hz && r_snz_pend) begin
      r_snz_cnt <= r_snz_cnt - 1'b1;
      if (r_snz_cnt == SNZ_W'(1)) r_snz_pend <= 1'b0;
    end
  end
`else
  logic w_unused_snooze;
  assign w_unused_snooze = ctrl.snooze_pulse ^ (SNOOZE_S == 0);
`endif

  always_ff @(posedge video_clk) begin
    if (reset) begin
      r_al_on <= 1'b0;
      r_alarm <= 1'b0;
      r_tmo   <= '0;
    end else begin
      if (ctrl.al_toggle_pulse) r_al_on <= ~r_al_on;

      if (w_turn_off) begin
        r_alarm <= 1'b0;
        r_tmo   <= '0;
      end else if (w_match) begin
        r_alarm <= 1'b1;
        r_tmo   <= TMO_W'(ALARM_TIMEOUT_S);
      end
`ifdef CLOCK_CTRL_SNOOZE_EN
      else if (ctrl.snooze_pulse && r_alarm) begin
        r_alarm <= 1'b0;
      end else if (w_snz_expire) begin
        r_alarm <= r_al_on;
        r_tmo   <= r_al_on ? TMO_W'(ALARM_TIMEOUT_S) : '0;
      end
`endif
      else if (ctrl.tick_1hz && r_alarm) begin
        r_tmo <= r_tmo - 1'b1;
        if (r_tmo == TMO_W'(1)) r_alarm <= 1'b0;
      end
    end
  end

  assign ctrl.hours      = w_hr;
  assign ctrl.minutes    = w_min;
  assign ctrl.seconds    = w_sec;
  assign ctrl.al_hours   = w_al_hr;
  assign ctrl.al_minutes = w_al_min;
  assign ctrl.al_on      = r_al_on;
  assign ctrl.alarm      = r_alarm;
  assign ctrl.edit_field = r_state;
  assign ctrl.blink      = r_blink;

endmodule
